// File: rtl/adc_pkg.sv
// Shared types and constants for the multi-channel XADC sampler.
package adc_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        COMMIT = 3'd3,
        SCALE  = 3'd4
    } state_t;

    // XADC auxiliary channel DRP addresses
    localparam logic [6:0] VAUX6  = 7'h16;
    localparam logic [6:0] VAUX7  = 7'h17;
    localparam logic [6:0] VAUX14 = 7'h1e;
    localparam logic [6:0] VAUX15 = 7'h1f;

    // Default channel map, channel 0 in the LSBs
    localparam logic [27:0] DEF_CH_ADDR = {VAUX6, VAUX7, VAUX14, VAUX15};

    // 16'hFFFF * 1250 >> 13 = 9999 mV full scale
    localparam int DEF_SCALE_MUL   = 1250;
    localparam int DEF_SCALE_SHIFT = 13;

endpackage

// File: rtl/adc_ch_accum.sv
// Per-channel datapath: sample staging, block accumulator, average and mV scaling.
module adc_ch_accum
    import adc_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int POWER       = 8,
    parameter int SCALE_MUL   = DEF_SCALE_MUL,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] din,
    input  logic              capture,
    input  logic              commit,
    input  logic              dump,
    input  logic              scale,
    output logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] ave,
    output logic [DATA_W-1:0] scaled
);

    localparam int ACC_W  = DATA_W + POWER;
    localparam int PROD_W = DATA_W + $clog2(SCALE_MUL) + 1;

    logic [DATA_W-1:0] stage;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic [PROD_W-1:0] prod;

    // Accumulator cannot overflow: ACC_W holds 2**POWER full-scale samples
    assign sum  = acc + ACC_W'(stage);
    assign prod = PROD_W'(ave) * PROD_W'(SCALE_MUL);

    // Capture, accumulate-or-dump, and scale registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage  <= '0;
            raw    <= '0;
            acc    <= '0;
            ave    <= '0;
            scaled <= '0;
        end else begin
            if (capture) begin
                stage <= din;
                raw   <= din;
            end
            if (commit) begin
                if (dump) begin
                    acc <= '0;
                    ave <= sum[POWER +: DATA_W];
                end else begin
                    acc <= sum;
                end
            end
            if (scale) begin
                scaled <= DATA_W'(prod >> SCALE_SHIFT);
            end
        end
    end

endmodule

// File: rtl/adc_multi_sampler.sv
// DRP read master for xadc_wiz: reads NUM_CH channels per end-of-sequence,
// block-averages 2**POWER sequences and scales the result to millivolts.
// DRP handshake: den_out is a one-cycle request with daddr_out valid in the
// same cycle; daddr_out then holds until drdy_in (data valid on do_in in that
// cycle) or until the wait times out. dwe_out is tied low (read-only master).
module adc_multi_sampler
    import adc_pkg::*;
#(
    parameter int                  NUM_CH      = 4,
    parameter int                  DATA_W      = 16,
    parameter int                  POWER       = 8,
    parameter logic [NUM_CH*7-1:0] CH_ADDR     = DEF_CH_ADDR,
    parameter int                  TIMEOUT     = 255,
    parameter int                  SCALE_MUL   = DEF_SCALE_MUL,
    parameter int                  SCALE_SHIFT = DEF_SCALE_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     eos_in,
    input  logic                     drdy_in,
    input  logic [DATA_W-1:0]        do_in,
    output logic                     den_out,
    output logic [6:0]               daddr_out,
    output logic                     dwe_out,
    output logic [NUM_CH*DATA_W-1:0] raw_data_out,
    output logic [NUM_CH*DATA_W-1:0] ave_data_out,
    output logic [NUM_CH*DATA_W-1:0] scaled_data_out,
    output logic                     ave_valid,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     overrun_err,
    output logic [2:0]               state_dbg
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t           state, next_state;
    logic [CH_W-1:0]  ch_idx, next_ch;
    logic [TO_W-1:0]  to_cnt;
    logic [POWER-1:0] sample_cnt;
    logic             eos_r;
    logic             eos_pulse;
    logic             drdy_hit;
    logic             to_hit;
    logic             commit;
    logic             dump;
    logic             scale;
    logic [6:0]       addr_tab [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_addr
        assign addr_tab[c] = CH_ADDR[c*7 +: 7];
    end

    assign eos_pulse = eos_in & ~eos_r;
    assign drdy_hit  = (state == WAIT) && drdy_in;
    assign to_hit    = (state == WAIT) && !drdy_in && (to_cnt == TO_W'(TIMEOUT));
    assign commit    = (state == COMMIT);
    assign dump      = commit && (sample_cnt == {POWER{1'b1}});
    assign scale     = (state == SCALE);
    assign busy      = (state != IDLE);
    assign dwe_out   = 1'b0;
    assign state_dbg = state;

    // Next-state and channel-index selection
    always_comb begin
        next_state = state;
        next_ch    = ch_idx;
        case (state)
            IDLE: begin
                if (eos_pulse) begin
                    next_state = REQ;
                    next_ch    = '0;
                end
            end
            REQ:  next_state = WAIT;
            WAIT: begin
                if (drdy_in) begin
                    if (ch_idx == CH_W'(NUM_CH - 1)) begin
                        next_state = COMMIT;
                    end else begin
                        next_ch    = ch_idx + 1'b1;
                        next_state = REQ;
                    end
                end else if (to_hit) begin
                    next_state = IDLE;
                end
            end
            COMMIT: next_state = dump ? SCALE : IDLE;
            SCALE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, DRP request registers, counters and sticky flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ch_idx      <= '0;
            eos_r       <= 1'b0;
            den_out     <= 1'b0;
            daddr_out   <= CH_ADDR[6:0];
            to_cnt      <= '0;
            sample_cnt  <= '0;
            ave_valid   <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state     <= next_state;
            ch_idx    <= next_ch;
            eos_r     <= eos_in;
            // Registered so den/daddr are glitch-free during the REQ cycle
            den_out   <= (next_state == REQ);
            if (next_state == REQ) begin
                daddr_out <= addr_tab[next_ch];
            end
            if (state == REQ) begin
                to_cnt <= '0;
            end else if ((state == WAIT) && !drdy_in && !to_hit) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (commit) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
            ave_valid <= scale;
            if (to_hit) begin
                timeout_err <= 1'b1;
            end
            if (eos_pulse && (state != IDLE)) begin
                overrun_err <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        adc_ch_accum #(
            .DATA_W      (DATA_W),
            .POWER       (POWER),
            .SCALE_MUL   (SCALE_MUL),
            .SCALE_SHIFT (SCALE_SHIFT)
        ) u_accum (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (do_in),
            .capture (drdy_hit && (ch_idx == CH_W'(c))),
            .commit  (commit),
            .dump    (dump),
            .scale   (scale),
            .raw     (raw_data_out[c*DATA_W +: DATA_W]),
            .ave     (ave_data_out[c*DATA_W +: DATA_W]),
            .scaled  (scaled_data_out[c*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_adc_multi_sampler.sv
// Bench for adc_multi_sampler: NUM_CH=4, POWER=2 with a behavioural XADC DRP
// responder that returns drdy 4 cycles after den.
module tb_adc_multi_sampler;

    localparam int NUM_CH = 4;
    localparam int DW     = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic                 eos_in = 1'b0;
    logic                 drdy_in = 1'b0;
    logic [DW-1:0]        do_in = '0;
    logic                 den_out;
    logic [6:0]           daddr_out;
    logic                 dwe_out;
    logic [NUM_CH*DW-1:0] raw_data_out;
    logic [NUM_CH*DW-1:0] ave_data_out;
    logic [NUM_CH*DW-1:0] scaled_data_out;
    logic                 ave_valid;
    logic                 busy;
    logic                 timeout_err;
    logic                 overrun_err;
    logic [2:0]           state_dbg;

    adc_multi_sampler #(
        .NUM_CH (NUM_CH),
        .DATA_W (DW),
        .POWER  (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .eos_in          (eos_in),
        .drdy_in         (drdy_in),
        .do_in           (do_in),
        .den_out         (den_out),
        .daddr_out       (daddr_out),
        .dwe_out         (dwe_out),
        .raw_data_out    (raw_data_out),
        .ave_data_out    (ave_data_out),
        .scaled_data_out (scaled_data_out),
        .ave_valid       (ave_valid),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .overrun_err     (overrun_err),
        .state_dbg       (state_dbg)
    );

    // ---------------- DRP model ----------------
    logic [DW-1:0] ch_val [NUM_CH];
    int            withhold_ch = -1;
    int            pend = 0;
    int            pend_ch = 0;
    int            den_cnt = 0;
    int            ave_cnt = 0;
    logic [6:0]    addr_q [$];

    function automatic int addr_ch(input logic [6:0] a);
        case (a)
            7'h1f:   return 0;
            7'h1e:   return 1;
            7'h17:   return 2;
            7'h16:   return 3;
            default: return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        drdy_in = 1'b0;
        if (!reset_n) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drdy_in = 1'b1;
                    do_in   = ch_val[pend_ch];
                end
            end
            if (den_out) begin
                den_cnt++;
                addr_q.push_back(daddr_out);
                if (addr_ch(daddr_out) != withhold_ch) begin
                    pend    = 4;
                    pend_ch = addr_ch(daddr_out);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && ave_valid) ave_cnt++;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] raw_of(input int c);
        return raw_data_out[c*DW +: DW];
    endfunction
    function automatic logic [DW-1:0] ave_of(input int c);
        return ave_data_out[c*DW +: DW];
    endfunction
    function automatic logic [DW-1:0] scl_of(input int c);
        return scaled_data_out[c*DW +: DW];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_vals(input logic [DW-1:0] v0, v1, v2, v3);
        ch_val[0] = v0; ch_val[1] = v1; ch_val[2] = v2; ch_val[3] = v3;
    endtask

    task automatic run_seq(output int cyc);
        @(negedge clk); eos_in = 1'b1;
        @(negedge clk); eos_in = 1'b0;
        cyc = 1;
        while (busy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (busy) check("seq_bound", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0][DW-1:0] smp;
        logic [3:0][DW-1:0] ave;
        logic [3:0][DW-1:0] scl;
    } vec_t;

    vec_t       vecs [2];
    logic [6:0] exp_addr [4];
    int         cyc, d0, a0;

    initial begin
        // Full-scale/midscale block, then an arbitrary block
        vecs[0].smp = {16'h0000, 16'h1000, 16'h8000, 16'hFFFF};
        vecs[0].ave = {16'h0000, 16'h1000, 16'h8000, 16'hFFFF};
        vecs[0].scl = {16'd0,    16'd625,  16'd5000, 16'd9999};
        vecs[1].smp = {16'hABCD, 16'h7FFF, 16'h0001, 16'h1234};
        vecs[1].ave = {16'hABCD, 16'h7FFF, 16'h0001, 16'h1234};
        vecs[1].scl = {16'd6710, 16'd4999, 16'd0,    16'd711};
        exp_addr[0] = 7'h1f; exp_addr[1] = 7'h1e;
        exp_addr[2] = 7'h17; exp_addr[3] = 7'h16;
        set_vals(16'd0, 16'd0, 16'd0, 16'd0);

        // Reset state
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_daddr", 32'(daddr_out), 32'h1f);
        check("rst_den", 32'(den_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dwe", 32'(dwe_out), 32'd0);
        check("rst_flags", {30'd0, timeout_err, overrun_err}, 32'd0);
        check("rst_valid", 32'(ave_valid), 32'd0);
        check("rst_raw_or", 32'(|{raw_data_out, ave_data_out, scaled_data_out}), 32'd0);

        // One sequence: address order and raw capture
        set_vals(16'd11, 16'd22, 16'd33, 16'd44);
        d0 = den_cnt; a0 = ave_cnt; addr_q.delete();
        run_seq(cyc);
        check("ord_den_cnt", 32'(den_cnt - d0), 32'd4);
        check("ord_addr_n", 32'(addr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (addr_q.size() > i) check($sformatf("ord_addr%0d", i), 32'(addr_q[i]), 32'(exp_addr[i]));
            check($sformatf("ord_raw%0d", i), 32'(raw_of(i)), 32'(ch_val[i]));
        end
        check("ord_no_valid", 32'(ave_cnt - a0), 32'd0);

        // Table-driven blocks of four identical sequences
        do_reset();
        for (int v = 0; v < 2; v++) begin
            set_vals(vecs[v].smp[0], vecs[v].smp[1], vecs[v].smp[2], vecs[v].smp[3]);
            a0 = ave_cnt;
            for (int s = 0; s < 4; s++) run_seq(cyc);
            check($sformatf("vec%0d_valid", v), 32'(ave_cnt - a0), 32'd1);
            for (int c = 0; c < 4; c++) begin
                check($sformatf("vec%0d_ave%0d", v, c), 32'(ave_of(c)), 32'(vecs[v].ave[c]));
                check($sformatf("vec%0d_scl%0d", v, c), 32'(scl_of(c)), 32'(vecs[v].scl[c]));
            end
        end

        // Varying samples on ch0, then a block from a cleared accumulator
        set_vals(16'd100, 16'd4, 16'd4, 16'd4); run_seq(cyc);
        ch_val[0] = 16'd200; run_seq(cyc);
        ch_val[0] = 16'd300; run_seq(cyc);
        ch_val[0] = 16'd401; run_seq(cyc);
        check("var_ave0", 32'(ave_of(0)), 32'd250);
        check("var_scl0", 32'(scl_of(0)), 32'd38);
        check("var_ave1", 32'(ave_of(1)), 32'd4);
        ch_val[0] = 16'd8;
        for (int s = 0; s < 4; s++) run_seq(cyc);
        check("clr_ave0", 32'(ave_of(0)), 32'd8);

        // Timeout on ch2
        set_vals(16'd1000, 16'd1000, 16'd1000, 16'd1000);
        withhold_ch = 2; d0 = den_cnt; a0 = ave_cnt;
        run_seq(cyc);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_min_cycles", 32'(cyc >= 255 && cyc <= 320), 32'd1);
        check("to_den_cnt", 32'(den_cnt - d0), 32'd3);
        check("to_raw0", 32'(raw_of(0)), 32'd1000);
        check("to_raw2_kept", 32'(raw_of(2)), 32'd4);
        check("to_no_valid", 32'(ave_cnt - a0), 32'd0);
        withhold_ch = -1;
        set_vals(16'd40, 16'd80, 16'd120, 16'd160);
        for (int s = 0; s < 4; s++) run_seq(cyc);
        check("post_to_valid", 32'(ave_cnt - a0), 32'd1);
        check("post_to_ave0", 32'(ave_of(0)), 32'd40);
        check("post_to_ave1", 32'(ave_of(1)), 32'd80);
        check("post_to_ave2", 32'(ave_of(2)), 32'd120);
        check("post_to_ave3", 32'(ave_of(3)), 32'd160);
        check("post_to_scl3", 32'(scl_of(3)), 32'd24);

        // Overrun: second eos mid-sequence
        set_vals(16'd5, 16'd6, 16'd7, 16'd9);
        d0 = den_cnt;
        @(negedge clk); eos_in = 1'b1;
        @(negedge clk); eos_in = 1'b0;
        repeat (3) @(negedge clk);
        eos_in = 1'b1;
        @(negedge clk); eos_in = 1'b0;
        cyc = 0;
        while (busy && cyc < 2000) begin @(negedge clk); cyc++; end
        if (busy) check("ovr_bound", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("ovr_err", 32'(overrun_err), 32'd1);
        check("ovr_to_sticky", 32'(timeout_err), 32'd1);
        check("ovr_den_cnt", 32'(den_cnt - d0), 32'd4);
        check("ovr_raw3", 32'(raw_of(3)), 32'd9);

        // Reset during WAIT
        set_vals(16'd20, 16'd20, 16'd20, 16'd20);
        a0 = ave_cnt;
        @(negedge clk); eos_in = 1'b1;
        @(negedge clk); eos_in = 1'b0;
        @(negedge clk);
        check("pre_rst_wait", 32'(state_dbg), 32'd2);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_flags", {30'd0, timeout_err, overrun_err}, 32'd0);
        check("mid_rst_daddr", 32'(daddr_out), 32'h1f);
        check("mid_rst_raw", 32'(|raw_data_out), 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_rst_no_valid", 32'(ave_cnt - a0), 32'd0);
        for (int s = 0; s < 3; s++) run_seq(cyc);
        check("rst_blk_3seq", 32'(ave_cnt - a0), 32'd0);
        run_seq(cyc);
        check("rst_blk_4seq", 32'(ave_cnt - a0), 32'd1);
        check("rst_blk_ave0", 32'(ave_of(0)), 32'd20);
        check("rst_blk_scl0", 32'(scl_of(0)), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_multi_sampler.md
Name: adc_multi_sampler

Overview:
- Parametrised multi-channel successor to the single-channel XADC front end.
- Acts as a DRP read master for an externally instantiated xadc_wiz (sequencer mode). On each end-of-sequence it reads NUM_CH auxiliary channels.
- Block-averages 2**POWER complete sequences per channel and outputs raw, averaged and millivolt-scaled data per channel to the display/UART layers.

Parameters:
- NUM_CH, 4, number of channels read per sequence (1..8).
- DATA_W, 16, DRP data width.
- POWER, 8, log2 of sequences averaged per output.
- CH_ADDR, {7'h16,7'h17,7'h1e,7'h1f}, packed NUM_CH*7 DRP addresses; channel 0 is in the LSBs (7'h1f = VAUX15).
- TIMEOUT, 255, maximum cycles to wait for drdy_in.
- SCALE_MUL, 1250, scale multiplier.
- SCALE_SHIFT, 13, scale right-shift (full scale 16'hFFFF maps to 9999).

Ports:
- clk  in  1  system clock, also the DRP dclk.
- reset_n  in  1  asynchronous, active-low reset.
- eos_in  in  1  XADC end-of-sequence (level or pulse; edge-detected internally).
- drdy_in  in  1  DRP data ready.
- do_in  in  DATA_W  DRP read data.
- den_out  out  1  DRP enable, one-cycle pulse.
- daddr_out  out  7  DRP address.
- dwe_out  out  1  constant 0.
- raw_data_out  out  NUM_CH*DATA_W  last sample read per channel.
- ave_data_out  out  NUM_CH*DATA_W  block averages.
- scaled_data_out  out  NUM_CH*DATA_W  millivolt values.
- ave_valid  out  1  one-cycle pulse when ave_data_out and scaled_data_out update.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky.
- overrun_err  out  1  sticky.

Behaviour:
- Reset: all outputs, accumulators, staging registers, sample counter and flags go to 0. daddr_out resets to CH_ADDR[0]. State goes to IDLE. Reset asserted mid-sequence aborts immediately; no partial commit.
- eos rising edge: eos_in is registered; the pulse is eos & ~eos_r. In IDLE this sets ch_idx=0 and moves to REQ. While busy it sets overrun_err and is otherwise ignored.
- REQ:
  - daddr_out = CH_ADDR[ch_idx]; den_out = 1 for exactly this cycle.
  - Clear the timeout counter; go to WAIT.
  - daddr_out holds until drdy_in or timeout.
- WAIT, on drdy_in:
  - Capture do_in into stage[ch_idx] and raw_data_out[ch_idx] (visible the cycle after drdy_in).
  - If ch_idx == NUM_CH-1, go to COMMIT; else increment ch_idx and go to REQ.
  - Latency: 2 cycles per channel plus the DRP read time.
- WAIT, on timeout (counter reaches TIMEOUT with no drdy_in):
  - Set timeout_err and return to IDLE.
  - Staged samples are discarded. Accumulators and sample counter are unchanged.
  - raw_data_out keeps any values already captured.
- drdy_in outside WAIT is ignored.
- COMMIT (one cycle):
  - Each acc[c] (DATA_W+POWER bits, cannot overflow) += stage[c]; sample_cnt increments (POWER bits).
  - If sample_cnt == 2**POWER-1: ave_data_out[c] = (acc[c]+stage[c]) >> POWER (truncating), acc clears, sample_cnt wraps to 0, and state goes to SCALE; otherwise state goes to IDLE.
- SCALE (one cycle):
  - scaled_data_out[c] = (ave[c]*SCALE_MUL) >> SCALE_SHIFT, product width DATA_W+clog2(SCALE_MUL)+1, truncated to DATA_W.
  - ave_valid pulses with the scaled register update; state returns to IDLE.
  - Both output buses become stable together; consumers sample them on ave_valid.
- eos during COMMIT/SCALE counts as overrun.
- Flags clear only on reset.

Decomposition:
- Package adc_pkg: state typedef (IDLE, REQ, WAIT, COMMIT, SCALE), XADC VAUX address constants (VAUX6=7'h16, VAUX7=7'h17, VAUX14=7'h1e, VAUX15=7'h1f), default scale constants.
- Sub-module adc_ch_accum: one per channel via generate. Holds stage register, accumulator, average and scaled registers. Controls in: capture, commit, dump, scale.
- The top level holds the FSM, DRP interface, counters and flags.

Test Plan (bench: NUM_CH=4, POWER=2, XADC DRP behavioural model, drdy 4 cycles after den):
- Reset check: hold reset_n low, release -> all outputs 0, den_out 0, busy 0, daddr_out=7'h1f.
- Sequence order: 1 eos -> den pulses exactly 4 times at addresses 1f, 1e, 17, 16 in that order; raw_data_out updates per channel; no ave_valid.
- Full scale and midscale: ch0=FFFF, ch1=8000, ch2=1000, ch3=0000 for 4 eos -> one ave_valid; ave = FFFF/8000/1000/0000; scaled = 9999/5000/625/0.
- Varying samples: ch0 gets 100, 200, 300, 401 -> ave_data_out[0]=250; next block starts from a cleared accumulator.
- Timeout: model withholds drdy for ch2 -> timeout_err=1 after 255 wait cycles, IDLE; a following 4 good sequences give averages excluding the aborted one.
- Overrun and reset: eos mid-sequence -> overrun_err=1, sequence completes normally; reset_n low during WAIT -> IDLE, no ave_valid, flags 0.
